// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deserialises RX_W-bit command frames, serialises one TX_W-bit read byte on MISO.
// Latency: rx_valid one cycle after the last frame bit; MISO carries tx_data MSB the cycle after tx_valid.
// No backpressure: rx_valid is a strobe, tx_valid is honoured only while waiting for read data.
module spi_slave_if #(
   parameter int RX_W = 10,
   parameter int TX_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            SS_n,
   input  logic            MOSI,
   output logic            MISO,
   output logic [RX_W-1:0] rx_data,
   output logic            rx_valid,
   input  logic [TX_W-1:0] tx_data,
   input  logic            tx_valid
);

   localparam int CW  = $clog2(RX_W);
   localparam int TCW = $clog2(TX_W);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, HOLD
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   bit_cnt;
   logic [RX_W-2:0] rx_sr;
   logic [TX_W-1:0] tx_sr;
   logic [TCW-1:0]  tx_cnt;
   logic            rd_addr_seen;

   logic abort, cmd_bit, rx_shift, rx_last, tx_load, tx_step, tx_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (SS_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      state_nxt = CHK_CMD;
            CHK_CMD:   state_nxt = MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
            WRITE,
            READ_ADD:  if (rx_last) state_nxt = HOLD;
            READ_DATA: if (rx_last) state_nxt = RD_WAIT;
            RD_WAIT:   if (tx_valid) state_nxt = RD_SHIFT;
            RD_SHIFT:  if (tx_cnt == '0) state_nxt = HOLD;
            default:   state_nxt = state;
         endcase
      end
   end

   always_comb begin
      abort    = SS_n && (state != IDLE);
      cmd_bit  = !SS_n && (state == CHK_CMD);
      rx_shift = !SS_n && ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA));
      rx_last  = rx_shift && (bit_cnt == CW'(RX_W-1));
      tx_load  = !SS_n && (state == RD_WAIT) && tx_valid;
      tx_step  = !SS_n && (state == RD_SHIFT) && (tx_cnt != '0);
      tx_end   = !SS_n && (state == RD_SHIFT) && (tx_cnt == '0);
   end

   // Receive path: bit_cnt counts bits already held in rx_sr, so the last bit is merged on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt      <= '0;
         rx_sr        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
      end else begin
         rx_valid <= rx_last;
         if (cmd_bit) begin
            rx_sr   <= {{(RX_W-2){1'b0}}, MOSI};
            bit_cnt <= CW'(1);
         end else if (rx_last) begin
            rx_data <= {rx_sr, MOSI};
            bit_cnt <= '0;
         end else if (rx_shift) begin
            rx_sr   <= {rx_sr[RX_W-3:0], MOSI};
            bit_cnt <= bit_cnt + 1'b1;
         end else begin
            bit_cnt <= '0;
         end
         if (rx_last && (state == READ_ADD))
            rd_addr_seen <= 1'b1;
         else if (tx_end || (abort && (state == RD_SHIFT)))
            rd_addr_seen <= 1'b0;
      end
   end

   // Transmit path: MSB goes straight to MISO on load, the rest follows from tx_sr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MISO   <= 1'b0;
         tx_sr  <= '0;
         tx_cnt <= '0;
      end else if (tx_load) begin
         MISO   <= tx_data[TX_W-1];
         tx_sr  <= {tx_data[TX_W-2:0], 1'b0};
         tx_cnt <= TCW'(TX_W-1);
      end else if (tx_step) begin
         MISO   <= tx_sr[TX_W-1];
         tx_sr  <= {tx_sr[TX_W-2:0], 1'b0};
         tx_cnt <= tx_cnt - 1'b1;
      end else begin
         MISO <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Frame-level randomized bench for spi_slave_if: each frame's expected strobe,
// word and MISO stream are predicted from the frame contents and routing history.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;

   int         total = 0;
   int         bad = 0;
   bit         seen = 1'b0;
   logic [9:0] last_rx = 10'h000;

   spi_slave_if #(.RX_W(10), .TX_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
      SS_n     = ss;
      MOSI     = mosi;
      tx_valid = txv;
      tx_data  = txd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rtick(input logic ss);
      tick(ss, 1'($urandom), 1'($urandom), 8'($urandom));
   endtask

   task automatic expect_out(input string tag, input logic ev, input logic em);
      chk({tag, ".vld"},  32'(rx_valid), 32'(ev));
      chk({tag, ".miso"}, 32'(MISO),     32'(em));
      chk({tag, ".dat"},  32'(rx_data),  32'(last_rx));
   endtask

   // nbits: bits sent before SS_n rises (10 = full frame).
   // ntx: MISO bits observed before SS_n rises (-1 = abort while waiting, 8 = full byte).
   task automatic frame(input logic [9:0] w, input int nbits, input int txdly,
                        input logic [7:0] txb, input int ntx, input bit do_rst);
      int route;
      route = !w[9] ? 0 : (seen ? 2 : 1);
      rtick(1'b0);
      expect_out("enter", 1'b0, 1'b0);
      for (int i = 0; i < nbits && i < 10; i++) begin
         tick(1'b0, w[9-i], 1'($urandom), 8'($urandom));
         if (i == 9) last_rx = w;
         expect_out("bit", i == 9, 1'b0);
      end
      if (nbits < 10) begin
         tick(1'b1, w[9-nbits], 1'($urandom), 8'($urandom));
         expect_out("abort", 1'b0, 1'b0);
         rtick(1'b1);
         expect_out("abort_idle", 1'b0, 1'b0);
         return;
      end
      if (route == 1) seen = 1'b1;
      if (route == 2) begin
         for (int i = 0; i < txdly; i++) begin
            tick(1'b0, 1'($urandom), 1'b0, 8'($urandom));
            expect_out("wait", 1'b0, 1'b0);
         end
         if (ntx >= 1) begin
            tick(1'b0, 1'($urandom), 1'b1, txb);
            expect_out("load", 1'b0, txb[7]);
            seen = 1'b0;
            for (int b = 1; b < ntx && b < 8; b++) begin
               rtick(1'b0);
               expect_out("shift", 1'b0, txb[7-b]);
            end
            if (do_rst) begin
               rst_n   = 1'b0;
               last_rx = 10'h000;
               #1;
               expect_out("rst_mid", 1'b0, 1'b0);
               @(negedge clk);
               expect_out("rst_hold", 1'b0, 1'b0);
               rst_n = 1'b1;
               rtick(1'b1);
               expect_out("rst_idle", 1'b0, 1'b0);
               return;
            end
            if (ntx >= 8) begin
               for (int i = 0; i < 2; i++) begin
                  rtick(1'b0);
                  expect_out("tail", 1'b0, 1'b0);
               end
            end
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom), 1'b1, 8'hFF);
            expect_out("post", 1'b0, 1'b0);
         end
      end
      rtick(1'b1);
      expect_out("end", 1'b0, 1'b0);
      rtick(1'b1);
      expect_out("idle", 1'b0, 1'b0);
   endtask

   initial begin
      // Reset and idle
      repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00);
      expect_out("reset", 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rtick(1'b1);
         expect_out("idle5", 1'b0, 1'b0);
      end

      // Writes
      frame(10'b00_0000_0101, 10, 0, 8'h00, 8, 1'b0);
      frame(10'b01_1010_0101, 10, 0, 8'h00, 8, 1'b0);

      // Read address then read data returning 0xA5
      frame(10'b10_0000_0101, 10, 0, 8'h00, 8, 1'b0);
      frame(10'b11_0000_0000, 10, 0, 8'hA5, 8, 1'b0);

      // 1-prefixed frame after a completed read goes to READ_ADD
      frame(10'b11_0011_0011, 10, 0, 8'hFF, 8, 1'b0);

      // Abort after 6 bits, then a clean write
      frame(10'b01_1111_1111, 6, 0, 8'h00, 8, 1'b0);
      frame(10'b00_0000_0001, 10, 0, 8'h00, 8, 1'b0);

      // Abort on the last bit: the frame must be dropped
      frame(10'b00_1100_0011, 9, 0, 8'h00, 8, 1'b0);

      // Reset during shift-out of 0xFF, then next read frame routes to READ_ADD
      frame(10'b11_0000_0010, 10, 1, 8'hFF, 3, 1'b1);
      frame(10'b11_0101_0101, 10, 0, 8'hFF, 8, 1'b0);

      // Randomized frames
      for (int n = 0; n < 60; n++) begin
         logic [9:0] w;
         int         nb;
         int         nt;
         int         r;
         w  = 10'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10;
         r  = int'($urandom_range(0, 5));
         nt = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(1, 7)) : 8;
         frame(w, nb, int'($urandom_range(0, 3)), 8'($urandom), nt, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI-RAM subsystem; sits directly upstream of the RAM block.
- Deserialises MOSI frames into RX_W-bit command words and presents them on rx_data/rx_valid, which drive the RAM's din/rx_valid.
- For read-data frames it captures the RAM's dout/tx_valid and serialises the byte back out on MISO.
- clk serves as SPI SCK (mode 0: MOSI sampled, MISO updated on rising edge).

Parameters:
- RX_W, 10, command-frame width: 2-bit opcode in [RX_W-1:RX_W-2] plus 8-bit payload.
- TX_W, 8, read-data width returned on MISO.

Ports:
- clk  input  1  system/SPI clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; high aborts or ends a frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first; registered.
- rx_data  output  RX_W  assembled command word, to RAM din.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  TX_W  read byte from RAM dout.
- tx_valid  input  1  tx_data valid strobe from RAM.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0, tx shift reg=0.
- States:
  - IDLE: SS_n=0 -> CHK_CMD.
  - CHK_CMD: sample MOSI as frame bit RX_W-1. MOSI=0 -> WRITE. MOSI=1 & rd_addr_seen=0 -> READ_ADD. MOSI=1 & rd_addr_seen=1 -> READ_DATA.
  - WRITE, READ_ADD, READ_DATA: shift in remaining RX_W-1 bits, MSB first, one per cycle.
- rx_data load: in the cycle the last (RX_W-th) bit is sampled, rx_data loads the full word; rx_valid=1 for exactly the next cycle.
  - Frame latency: rx_valid is high RX_W+1 cycles after the CHK_CMD cycle's edge, counting CHK_CMD as cycle 1.
- Opcode routing: rx_data[RX_W-1:RX_W-2] carries the opcode as sent (00 wr addr, 01 wr data, 10 rd addr, 11 rd data). The slave does not modify it.
- WRITE / READ_ADD after the word is sent: remain in state and ignore further MOSI bits until SS_n=1, then -> IDLE.
  - READ_ADD sets rd_addr_seen=1 in the rx_valid cycle.
- READ_DATA after the word is sent:
  - Wait for tx_valid, indefinitely while SS_n=0, with MISO=0.
  - On the edge where tx_valid=1, latch tx_data. MISO then carries tx_data[TX_W-1] during the next cycle, through tx_data[0] TX_W cycles later.
  - After the last bit: MISO=0, rd_addr_seen cleared, wait for SS_n=1 -> IDLE.
- tx_valid outside the READ_DATA wait phase: ignored; no latch, no MISO change.
- tx_valid during shift-out: ignored; the byte in flight is not replaced.
- SS_n=1 in any non-IDLE state:
  - Next state IDLE; counter cleared; MISO=0 next cycle.
  - Partial frame discarded, no rx_valid.
  - rd_addr_seen unchanged, except it is cleared if the abort occurs after READ_DATA shift-out has started.
- SS_n=1 in the same cycle the last bit is sampled: that bit is discarded and rx_valid is not asserted (abort wins).
- rst_n asserted mid-frame: immediate return to reset values, including rd_addr_seen=0.
- rx_data holds its last value between strobes.

Test Plan:
1. Reset with SS_n=1, then idle 5 cycles -> MISO=0, rx_valid=0, rx_data=0x000 throughout.
2. Write frame:
   - Stimulus: SS_n low, MOSI shifts 10'b00_0000_0101, then SS_n high.
   - Response: one rx_valid pulse with rx_data=0x005.
   - Repeat with 10'b01_1010_0101 -> rx_data=0x1A5.
3. Read-address then read-data, with the RAM model returning 0xA5 one cycle after rx_valid:
   - Send 10'b10_0000_0101 -> rx_data=0x205, rd_addr_seen=1.
   - Send 10'b11_0000_0000 -> rx_data=0x300.
   - tx_valid/tx_data=0xA5 arrives -> MISO=1,0,1,0,0,1,0,1 on the 8 following cycles, then 0; rd_addr_seen=0.
4. A second 1-prefixed frame after test 3 -> routed to READ_ADD (rx_data=0x2xx). No MISO activity, since tx_valid is ignored in READ_ADD.
5. Abort: SS_n raised after the 6th bit of 10'b01_1111_1111 -> no rx_valid, state IDLE next cycle. A following full frame 10'b00_0000_0001 -> rx_data=0x001 with correct timing.
6. rst_n pulsed low during READ_DATA shift-out of 0xFF -> MISO=0 immediately. The next 1-prefixed frame goes to READ_ADD.
